// File: rtl/oam_dma.sv
// Sprite-DMA bus initiator: a CPU write to TRIGGER_ADDR halts the CPU and copies
// one 256-byte page from the CPU memory bus into the PPU OAM data port.
//
//   state   | meaning
//   S_IDLE  | CPU runs, waiting for a trigger write
//   S_HALT  | CPU halted, first stall cycle
//   S_ALIGN | extra stall so every READ lands on an even (odd=0) cycle
//   S_READ  | drive {page,idx} with oe_n low, capture the byte
//   S_WRITE | strobe the captured byte into OAM, advance idx
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_cpu_we,
    output logic        o_cpu_rdy,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_oe_n,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_oam_wr,
    output logic [7:0]  o_oam_wdata,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_latch;
    logic        r_odd;
    logic        w_trigger;

    assign w_trigger = i_cpu_we && (i_cpu_addr == TRIGGER_ADDR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_odd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_odd   <= ~r_odd;
        end
    end

    // idx wraps within the page; it never carries into page.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
        end else begin
            if (r_state == S_IDLE && w_trigger) begin
                r_page <= i_cpu_wdata;
                r_idx  <= 8'h00;
            end
            if (r_state == S_READ) begin
                r_latch <= i_mem_rdata;
            end
            if (r_state == S_WRITE && r_idx != 8'hFF) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_cpu_rdy   = 1'b0;
        o_busy      = 1'b1;
        o_mem_addr  = 16'h0000;
        o_mem_oe_n  = 1'b1;
        o_oam_wr    = 1'b0;
        o_oam_wdata = 8'h00;
        case (r_state)
            S_IDLE: begin
                o_cpu_rdy = 1'b1;
                o_busy    = 1'b0;
                if (w_trigger) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                w_state_nxt = r_odd ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                w_state_nxt = S_READ;
            end
            S_READ: begin
                o_mem_addr  = {r_page, r_idx};
                o_mem_oe_n  = 1'b0;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                o_oam_wr    = 1'b1;
                o_oam_wdata = r_latch;
                w_state_nxt = (r_idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: directed and randomized page transfers checked against a
// per-transfer reference of addresses, OAM bytes and stall length.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_rdy;
    logic [15:0] mem_addr;
    logic        mem_oe_n;
    logic [7:0]  mem_rdata;
    logic        oam_wr;
    logic [7:0]  oam_wdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] key = 8'h5A;
    assign mem_rdata = mem_oe_n ? 8'h00 : (mem_addr[7:0] ^ key);

    oam_dma dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_cpu_we    (cpu_we),
        .o_cpu_rdy   (cpu_rdy),
        .o_mem_addr  (mem_addr),
        .o_mem_oe_n  (mem_oe_n),
        .i_mem_rdata (mem_rdata),
        .o_oam_wr    (oam_wr),
        .o_oam_wdata (oam_wdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; its parity is the expected odd flag.
    int tb_edges = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_edges <= 0;
        else        tb_edges <= tb_edges + 1;
    end

    // Bus monitor, sampled mid-cycle.
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    int          low_cnt = 0;
    int          stall_cnt = 0;
    int          viol = 0;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!cpu_rdy) low_cnt++;
            if (!cpu_rdy && mem_oe_n && !oam_wr) stall_cnt++;
            if (busy !== !cpu_rdy) viol++;
            if (!mem_oe_n) begin
                rd_q.push_back(mem_addr);
                if (tb_edges % 2 != 0) viol++;
            end
            if (oam_wr) begin
                wr_q.push_back(oam_wdata);
                if (prev_wr || !prev_rd) viol++;
            end
            if (!mem_oe_n && oam_wr) viol++;
            prev_wr = oam_wr;
            prev_rd = !mem_oe_n;
        end else begin
            prev_wr = 1'b0;
            prev_rd = 1'b0;
        end
    end

    logic halt_odd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(posedge clk);
        #1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic trig(input logic [15:0] a, input logic [7:0] d);
        poke(a, d);
        halt_odd = (tb_edges % 2 != 0);
        rd_q.delete();
        wr_q.delete();
        low_cnt   = 0;
        stall_cnt = 0;
        viol      = 0;
    endtask

    // Position so the next sampling edge leaves odd == want during HALT.
    task automatic align_to(input bit want);
        @(negedge clk);
        if (((tb_edges + 1) % 2 != 0) != want) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_rdy && n < 700);
        chk({tag, "_done"}, {31'd0, cpu_rdy}, 32'd1);
    endtask

    task automatic wait_read(input string tag, input logic [15:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!mem_oe_n && mem_addr == a) && n < 700);
        chk({tag, "_reach"}, {16'd0, mem_addr}, {16'd0, a});
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] page);
        int bad = 0;
        logic [15:0] a;
        chk({tag, "_rdy_low"}, low_cnt, halt_odd ? 32'd513 : 32'd514);
        chk({tag, "_stall"}, stall_cnt, halt_odd ? 32'd1 : 32'd2);
        chk({tag, "_nreads"}, rd_q.size(), 32'd256);
        chk({tag, "_nstrobes"}, wr_q.size(), 32'd256);
        for (int k = 0; k < 256; k++) begin
            a = {page, k[7:0]};
            if (k >= rd_q.size() || rd_q[k] !== a) bad++;
            if (k >= wr_q.size() || wr_q[k] !== (a[7:0] ^ key)) bad++;
        end
        chk({tag, "_data"}, bad, 32'd0);
        chk({tag, "_protocol"}, viol, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},   {31'd0, cpu_rdy},  32'd1);
        chk({tag, "_busy"},  {31'd0, busy},     32'd0);
        chk({tag, "_oe_n"},  {31'd0, mem_oe_n}, 32'd1);
        chk({tag, "_addr"},  {16'd0, mem_addr}, 32'd0);
        chk({tag, "_wr"},    {31'd0, oam_wr},   32'd0);
        chk({tag, "_wdata"}, {24'd0, oam_wdata}, 32'd0);
    endtask

    initial begin
        int bad;
        logic [7:0] pg;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_rdy",  {31'd0, cpu_rdy}, 32'd1);
        chk("release_busy", {31'd0, busy},    32'd0);

        align_to(1'b1);
        trig(16'h4014, 8'h02);
        wait_idle("noalign");
        check_xfer("noalign", 8'h02);

        align_to(1'b0);
        trig(16'h4014, 8'h02);
        wait_idle("align");
        check_xfer("align", 8'h02);

        @(negedge clk);
        trig(16'h4015, 8'h03);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        chk("nomatch_busy", bad, 32'd0);
        chk("nomatch_reads", rd_q.size(), 32'd0);
        chk("nomatch_strobes", wr_q.size(), 32'd0);

        @(negedge clk);
        trig(16'h4014, 8'h03);
        wait_read("busytrig", 16'h0310);
        poke(16'h4014, 8'h07);
        wait_read("busytrig_last", 16'h03FF);
        @(negedge clk);
        chk("busytrig_final_wr", {31'd0, oam_wr}, 32'd1);
        poke(16'h4014, 8'h07);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        chk("busytrig_final_ignored", bad, 32'd0);
        check_xfer("busytrig", 8'h03);

        @(negedge clk);
        trig(16'h4014, 8'h03);
        wait_read("midreset", 16'h0340);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        trig(16'h4014, 8'hFF);
        wait_idle("pageff");
        check_xfer("pageff", 8'hFF);
        chk("pageff_idle", {31'd0, busy}, 32'd0);

        // Random pages and memory contents; the last one triggers in the
        // first IDLE cycle after the previous transfer.
        for (int r = 0; r < 3; r++) begin
            key = 8'($urandom);
            pg  = 8'($urandom);
            if (r < 2) repeat ($urandom_range(0, 3)) @(negedge clk);
            trig(16'h4014, pg);
            wait_idle("rand");
            check_xfer("rand", pg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA bus initiator for the NES CPU side. A CPU write to $4014 selects a 256-byte source page. The block then stalls the CPU and becomes the read master on the CPU memory bus, driving address and `oe_n` to the ROM/RAM responders. Each byte read is forwarded to the PPU OAM data port as a write strobe. It sits between the 6502 core, the memory responders and the PPU register interface.

## Interface
- `TRIGGER_ADDR`, 16'h4014, CPU write address that starts a transfer.
- `clk` in 1: system clock (CPU clock domain), rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_addr` in 16: CPU address bus.
- `cpu_wdata` in 8: CPU write data.
- `cpu_we` in 1: active-high, one-cycle CPU write strobe.
- `cpu_rdy` out 1: high = CPU may run; low = CPU halted by DMA.
- `mem_addr` out 16: read address driven to memory responders.
- `mem_oe_n` out 1: active-low output enable to memory responders.
- `mem_rdata` in 8: memory read data, valid in the same cycle `mem_oe_n`=0 (combinational responder).
- `oam_wr` out 1: one-cycle write strobe to the PPU OAM data port ($2004 semantics; PPU auto-increments).
- `oam_wdata` out 8: OAM write data, valid while `oam_wr`=1.
- `busy` out 1: high in any non-IDLE state.

## Operation
- Registers:
  - `state` ∈ {IDLE, HALT, ALIGN, READ, WRITE}.
  - `page[7:0]`.
  - `idx[7:0]`.
  - `latch[7:0]`.
  - `odd`: toggles every clock; resets to 0.
- Trigger = `cpu_we` && `cpu_addr`==TRIGGER_ADDR. It is only honoured in IDLE. On a trigger: `page`←`cpu_wdata`, `idx`←0, next state HALT.
- HALT (1 cycle): if `odd`=1, next state is READ; else next state is ALIGN. Result: READ always occurs in cycles with `odd`=0.
- ALIGN (1 cycle) → READ.
- READ:
  - `mem_addr`={`page`,`idx`} and `mem_oe_n`=0.
  - At the cycle's end, `latch`←`mem_rdata`.
  - Next state WRITE.
- WRITE:
  - `oam_wr`=1 and `oam_wdata`=`latch`.
  - If `idx`==8'hFF → IDLE; else `idx`←`idx`+1 and next state READ.
- Outputs are Moore decodes of registered state. Outside READ: `mem_oe_n`=1 and `mem_addr`=16'h0000.
- `cpu_rdy`=0 and `busy`=1 in HALT, ALIGN, READ and WRITE.
- Arithmetic: `idx` is 8 bits wide and never carries into `page`. Page $FF reads $FF00–$FFFF.
- Boundary cases:
  - A trigger while `busy`=1, including on the final WRITE cycle, is ignored; `page` and `idx` are unchanged.
  - A non-matching `cpu_addr` with `cpu_we`=1 has no effect.
  - Asserting `rst_n` mid-transfer aborts immediately. Outputs go to reset values with no partial strobe. A later trigger restarts at `idx`=0.

## Timing
- Reset values:
  - `cpu_rdy`=1, `busy`=0.
  - `mem_oe_n`=1, `mem_addr`=16'h0000.
  - `oam_wr`=0, `oam_wdata`=8'h00.
  - `state`=IDLE, `odd`=0, `page`=0, `idx`=0, `latch`=0.
- Trigger sampled on edge N → `cpu_rdy` falls for the cycle after edge N.
- Transfer length, counted as `cpu_rdy`-low cycles:
  - 513 (HALT + 256×(READ,WRITE)) when HALT has `odd`=1.
  - 514 when HALT has `odd`=0 (an ALIGN cycle is added).
- The read-to-OAM-write latency is exactly 1 cycle. WRITE k immediately follows READ k.
- `oam_wr` is never asserted on consecutive cycles. There are exactly 256 strobes per transfer.
- `cpu_rdy` returns high in the cycle after the last WRITE.
- A new trigger can be accepted in the first IDLE cycle.

## Test plan
- **Reset check:** hold `rst_n`=0 for 3 cycles → all outputs at their listed reset values; release → `cpu_rdy`=1, `busy`=0.
- **Normal transfer (no ALIGN):** memory model `mem[a]`=a[7:0]^8'h5A. Write 8'h02 to $4014 so HALT has `odd`=1 → `cpu_rdy` low for exactly 513 cycles and `mem_addr` sweeps $0200–$02FF. Expect 256 `oam_wr` pulses with data `k`^8'h5A in order, and no ALIGN cycle.
- **Normal transfer (with ALIGN):** same as above, but trigger one cycle later so HALT has `odd`=0 → 514 low cycles. READ cycles all have `odd`=0 and the data sequence is identical.
- **Non-matching write:** write 8'h03 to $4015 → `busy` stays 0 and no `mem_oe_n` or `oam_wr` activity.
- **Trigger while busy:** start page $03; at `idx`=8'h10, write 8'h07 to $4014 → transfer continues on page $03 through $03FF and ends after 256 strobes. `page` is unchanged.
- **Reset mid-transfer:** pulse `rst_n` low when `idx`=8'h40 → reset values appear asynchronously. Then trigger page $FF → first READ at $FF00, last at $FFFF, and `idx` wraps to IDLE with no carry.
